// File: rtl/bp_pkg.sv
// bp_pkg: shared counter states and in-flight queue entry for the branch predictor
package bp_pkg;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;
  localparam logic [1:0] CNT_RST = WNT;
  localparam int BP_IDX_W = 5;
  typedef struct packed {
    logic [BP_IDX_W-1:0] idx;
    logic pred;
  } bp_entry_t;
endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: 2-bit saturating counters, async read port and sync train port
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             train_en,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken
);
  logic [1:0] cnt [2**IDX_W];
  logic [1:0] cur, nxt;
  assign rd_taken = cnt[rd_idx][1];
  assign cur = cnt[train_idx];
  always_comb begin
    nxt = cur;
    nxt = train_taken ? (cur == ST ? ST : cur + 2'd1) : (cur == SNT ? SNT : cur - 2'd1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= CNT_RST;
    end else if (train_en) begin
      cnt[train_idx] <= nxt;
    end
  end
endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: predicts IF branches, tracks them in order, trains and flags mispredicts at EX
module branch_predict_ctrl
  import bp_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            if_valid,
  input  logic            if_is_branch,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  output logic            bp_full,
  input  logic            ex_resolve,
  input  logic            ex_taken,
  output logic            mispredict,
  output logic            mis_taken,
  output logic            bp_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0] count;
  bp_entry_t q [DEPTH];
  bp_entry_t head;
  logic [IDX_W-1:0] idx;
  logic push, pop, mis;
  assign idx = if_pc[IDX_W+1:2];
  assign head = q[rd_ptr];
  assign bp_full = count == (PTR_W+1)'(DEPTH);
  assign bp_empty = count == '0;
  assign pop = ex_resolve & !stall & !bp_empty;
  // a pop frees a slot on the same edge, so a full queue may still accept
  assign push = if_valid & if_is_branch & !stall & (!bp_full | pop);
  assign mis = pop & (ex_taken != head.pred);
  bp_counter_table #(.IDX_W(IDX_W)) u_table (
    .clk(clk),
    .rst(rst),
    .rd_idx(idx),
    .rd_taken(pred_taken),
    .train_en(pop),
    .train_idx(IDX_W'(head.idx)),
    .train_taken(ex_taken)
  );
  always_ff @(posedge clk) begin
    if (push & !mis) q[wr_ptr] <= '{idx: BP_IDX_W'(idx), pred: pred_taken};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      mispredict <= 1'b0;
      mis_taken <= 1'b0;
    end else begin
      mispredict <= mis;
      mis_taken <= mis & ex_taken;
      if (mis) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
      end else begin
        rd_ptr <= rd_ptr + PTR_W'(pop);
        wr_ptr <= wr_ptr + PTR_W'(push);
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed and random checks against a queue/array reference model
module tb_branch_predict_ctrl;
  logic clk = 0, rst = 0, stall = 0, if_valid = 0, if_is_branch = 0, ex_resolve = 0, ex_taken = 0;
  logic [31:0] if_pc = 0;
  logic pred_taken, bp_full, mispredict, mis_taken, bp_empty;
  int total = 0, bad = 0;
  typedef struct {int idx; bit pred;} ent_t;
  ent_t mq[$];
  int cnt[32];
  bit m_mis = 0, m_mt = 0, init = 0;

  branch_predict_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .if_valid(if_valid), .if_is_branch(if_is_branch),
    .if_pc(if_pc), .pred_taken(pred_taken), .bp_full(bp_full), .ex_resolve(ex_resolve),
    .ex_taken(ex_taken), .mispredict(mispredict), .mis_taken(mis_taken), .bp_empty(bp_empty)
  );

  always #5 clk = ~clk;

  function automatic int pidx(input logic [31:0] pc);
    return int'(pc[6:2]);
  endfunction

  function automatic bit mpred(input logic [31:0] pc);
    return cnt[pidx(pc)] >= 2;
  endfunction

  task automatic chk(input string n, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%b exp=%b at %0t", n, a, e, $time);
    end
  endtask

  task automatic compare();
    chk("pred_taken", pred_taken, mpred(if_pc));
    chk("bp_full", bp_full, mq.size() == 4);
    chk("bp_empty", bp_empty, mq.size() == 0);
    chk("mispredict", mispredict, m_mis);
    if (m_mis) chk("mis_taken", mis_taken, m_mt);
  endtask

  task automatic step();
    bit pop, push, p;
    ent_t e;
    if (rst) begin
      foreach (cnt[i]) cnt[i] = 1;
      mq.delete();
      m_mis = 0;
      m_mt = 0;
      init = 1;
      return;
    end
    m_mis = 0;
    m_mt = 0;
    if (stall) return;
    pop = ex_resolve && mq.size() > 0;
    push = if_valid && if_is_branch && (mq.size() < 4 || pop);
    p = mpred(if_pc);
    if (pop) begin
      e = mq.pop_front();
      cnt[e.idx] = ex_taken ? (cnt[e.idx] < 3 ? cnt[e.idx] + 1 : 3) : (cnt[e.idx] > 0 ? cnt[e.idx] - 1 : 0);
      if (ex_taken != e.pred) begin
        m_mis = 1;
        m_mt = ex_taken;
        mq.delete();
        return;
      end
    end
    if (push) mq.push_back('{pidx(if_pc), p});
  endtask

  task automatic cyc(input bit r, s, v, b, input logic [31:0] pc, input bit res, tk);
    rst = r; stall = s; if_valid = v; if_is_branch = b; if_pc = pc; ex_resolve = res; ex_taken = tk;
    @(negedge clk);
    if (init) compare();
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    cyc(0, 0, 0, 0, pc, 0, 0);
  endtask

  initial begin
    #1;
    cyc(1, 0, 0, 0, 32'h40, 0, 0);
    chk("rst_pred", pred_taken, 1'b0);
    chk("rst_empty", bp_empty, 1'b1);
    chk("rst_mis", mispredict, 1'b0);
    // test 1/2: first taken resolve mispredicts (WNT), then saturate at ST
    cyc(0, 0, 1, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 32'h40, 1, 1);
    chk("t2_mis", mispredict, 1'b1);
    chk("t2_mt", mis_taken, 1'b1);
    chk("t2_empty", bp_empty, 1'b1);
    chk("t1_pred_wt", pred_taken, 1'b1);
    idle(32'h40);
    chk("t2_pulse_end", mispredict, 1'b0);
    cyc(0, 0, 1, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 32'h40, 1, 1);
    chk("t1_no_mis", mispredict, 1'b0);
    cyc(0, 0, 1, 1, 32'h40, 0, 0);
    cyc(0, 0, 0, 0, 32'h40, 1, 1);
    chk("t1_sat_pred", pred_taken, 1'b1);
    chk("m_sat", cnt[16] == 3, 1'b1);
    // pre-train 0x08 toward taken so FIFO order becomes observable
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 1, 1, 32'h08, 0, 0);
      cyc(0, 0, 0, 0, 32'h08, 1, 1);
    end
    idle(32'h08);
    chk("pre_pred08", pred_taken, 1'b1);
    // test 3
    cyc(0, 0, 1, 1, 32'h00, 0, 0);
    cyc(0, 0, 1, 1, 32'h04, 0, 0);
    cyc(0, 0, 1, 1, 32'h08, 0, 0);
    cyc(0, 0, 1, 1, 32'h0c, 0, 0);
    chk("t3_full", bp_full, 1'b1);
    cyc(0, 0, 1, 1, 32'h10, 0, 0);
    chk("t3_blocked_full", bp_full, 1'b1);
    cyc(0, 0, 1, 1, 32'h14, 1, 0);
    chk("t3_pushpop_full", bp_full, 1'b1);
    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    chk("t3_o1", mispredict, 1'b0);
    cyc(0, 0, 0, 0, 32'h0, 1, 1);
    chk("t3_o2", mispredict, 1'b0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    chk("t3_o3", mispredict, 1'b0);
    cyc(0, 0, 0, 0, 32'h0, 1, 0);
    chk("t3_o4", mispredict, 1'b0);
    chk("t3_empty", bp_empty, 1'b1);
    // test 4
    cyc(0, 0, 1, 1, 32'h20, 0, 0);
    cyc(0, 0, 1, 1, 32'h24, 0, 0);
    cyc(0, 0, 1, 1, 32'h28, 0, 0);
    cyc(0, 0, 1, 1, 32'h2c, 1, 1);
    chk("t4_mis", mispredict, 1'b1);
    chk("t4_empty", bp_empty, 1'b1);
    idle(32'h20);
    chk("t4_trained", pred_taken, 1'b1);
    idle(32'h24);
    chk("t4_untrained", pred_taken, 1'b0);
    // test 5
    cyc(0, 0, 1, 1, 32'h30, 0, 0);
    cyc(0, 1, 1, 1, 32'h34, 1, 1);
    chk("t5_stall_mis", mispredict, 1'b0);
    chk("t5_stall_empty", bp_empty, 1'b0);
    cyc(0, 0, 0, 0, 32'h30, 1, 0);
    cyc(0, 0, 0, 0, 32'h30, 1, 1);
    chk("t5_empty_res", mispredict, 1'b0);
    chk("t5_pred", pred_taken, 1'b0);
    // test 6
    cyc(0, 0, 1, 1, 32'h44, 0, 0);
    cyc(0, 0, 1, 1, 32'h48, 0, 0);
    cyc(0, 0, 1, 1, 32'h4c, 0, 0);
    cyc(1, 0, 0, 0, 32'h40, 1, 1);
    chk("t6_empty", bp_empty, 1'b1);
    chk("t6_pred", pred_taken, 1'b0);
    chk("t6_mis", mispredict, 1'b0);
    chk("m_rst", cnt[16] == 1, 1'b1);
    // random
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] pc;
      pc = ($urandom & 32'hFFFF_FF80) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 6, pc, $urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
